// File: rtl/sa_perfmon_histogram_if.sv
// sa_perfmon_histogram_if: sample/clear/readout bundle between a FIFO monitor master and the histogram.
interface sa_perfmon_histogram_if #(
  parameter int COUNT_W   = 32,
  parameter int BIN_IDX_W = 4
);
  logic                 sample_en;
  logic                 clear;
  logic [31:0]          max;
  logic [31:0]          curr;
  logic [BIN_IDX_W-1:0] rd_idx;
  logic [COUNT_W-1:0]   rd_data;
  logic [COUNT_W-1:0]   total;
  logic                 sat;
  logic [31:0]          peak;
  modport master (
    output sample_en, clear, max, curr, rd_idx,
    input  rd_data, total, sat, peak
  );
  modport slave (
    input  sample_en, clear, max, curr, rd_idx,
    output rd_data, total, sat, peak
  );
endinterface

// File: rtl/sa_perfmon_histogram.sv
// sa_perfmon_histogram: two-stage FIFO occupancy histogram with saturating bins, total and sticky sat.
// Optional peak-depth tracking is enabled by defining SA_PERFMON_PEAK_EN.
module sa_perfmon_histogram #(
  parameter int NUM_BINS  = 16,
  parameter int COUNT_W   = 32,
  parameter int BIN_IDX_W = 4
) (
  input logic                   autosa_core_clk,
  input logic                   autosa_core_rstn,
  sa_perfmon_histogram_if.slave bus
);
  localparam int CMP_W = 32 + BIN_IDX_W;
  logic                 s1_vld_q, s1_vld_d;
  logic [31:0]          s1_curr_q, s1_max_q;
  logic [COUNT_W-1:0]   bin_q [NUM_BINS];
  logic [COUNT_W-1:0]   bin_d [NUM_BINS];
  logic [COUNT_W-1:0]   total_q, total_d, rd_data_q;
  logic                 sat_q, sat_d;
  logic [BIN_IDX_W-1:0] bin_sel;
  logic [CMP_W-1:0]     curr_x, max_x, lim;
  logic                 bin_full, total_full;
  assign s1_vld_d = bus.sample_en & ~bus.clear;
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      s1_vld_q  <= 1'b0;
      s1_curr_q <= '0;
      s1_max_q  <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      if (bus.sample_en) begin
        s1_curr_q <= bus.curr;
        s1_max_q  <= bus.max;
      end
    end
  end
  // Bin by counting thresholds curr*N >= i*max, avoiding a divider.
  assign curr_x = {{BIN_IDX_W{1'b0}}, s1_curr_q} << BIN_IDX_W;
  assign max_x  = {{BIN_IDX_W{1'b0}}, s1_max_q};
  always_comb begin
    bin_sel = '0;
    lim     = '0;
    for (int i = 1; i < NUM_BINS; i++) begin
      lim = CMP_W'(i) * max_x;
      bin_sel = (curr_x >= lim) ? bin_sel + BIN_IDX_W'(1) : bin_sel;
    end
    bin_sel = (s1_max_q == '0) ? '0 :
              (s1_curr_q >= s1_max_q) ? BIN_IDX_W'(NUM_BINS - 1) : bin_sel;
  end
  assign bin_full   = &bin_q[bin_sel];
  assign total_full = &total_q;
  always_comb begin
    bin_d   = bin_q;
    total_d = total_q;
    sat_d   = sat_q;
    if (s1_vld_q) begin
      bin_d[bin_sel] = bin_full ? bin_q[bin_sel] : bin_q[bin_sel] + COUNT_W'(1);
      total_d        = total_full ? total_q : total_q + COUNT_W'(1);
      sat_d          = sat_q | bin_full | total_full;
    end
    if (bus.clear) begin
      for (int i = 0; i < NUM_BINS; i++) bin_d[i] = '0;
      total_d = '0;
      sat_d   = 1'b0;
    end
  end
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      for (int i = 0; i < NUM_BINS; i++) bin_q[i] <= '0;
      total_q   <= '0;
      sat_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      bin_q     <= bin_d;
      total_q   <= total_d;
      sat_q     <= sat_d;
      rd_data_q <= bin_q[bus.rd_idx];
    end
  end
  assign bus.rd_data = rd_data_q;
  assign bus.total   = total_q;
  assign bus.sat     = sat_q;
`ifdef SA_PERFMON_PEAK_EN
  logic [31:0] peak_q, peak_d;
  always_comb begin
    peak_d = peak_q;
    if (s1_vld_q && s1_curr_q > peak_q) peak_d = s1_curr_q;
    if (bus.clear) peak_d = '0;
  end
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) peak_q <= '0;
    else peak_q <= peak_d;
  end
  assign bus.peak = peak_q;
`else
  assign bus.peak = 32'd0;
`endif
endmodule

// File: tb/tb_sa_perfmon_histogram.sv
// tb_sa_perfmon_histogram: directed stimulus against a 32-bit and a 4-bit-counter instance,
// checked every cycle against a division-based model plus literal expectations.
module tb_sa_perfmon_histogram;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0, clr = 1'b0;
  logic [31:0] mx = '0, cu = '0;
  logic [3:0] ri = '0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  sa_perfmon_histogram_if #(.COUNT_W(32), .BIN_IDX_W(4)) if0 ();
  sa_perfmon_histogram_if #(.COUNT_W(4),  .BIN_IDX_W(4)) if1 ();
  assign if0.sample_en = en;  assign if1.sample_en = en;
  assign if0.clear = clr;     assign if1.clear = clr;
  assign if0.max = mx;        assign if1.max = mx;
  assign if0.curr = cu;       assign if1.curr = cu;
  assign if0.rd_idx = ri;     assign if1.rd_idx = ri;

  sa_perfmon_histogram #(.NUM_BINS(16), .COUNT_W(32), .BIN_IDX_W(4)) d0 (
    .autosa_core_clk(clk), .autosa_core_rstn(rstn), .bus(if0));
  sa_perfmon_histogram #(.NUM_BINS(16), .COUNT_W(4), .BIN_IDX_W(4)) d1 (
    .autosa_core_clk(clk), .autosa_core_rstn(rstn), .bus(if1));

  longint unsigned m_bin [2][16];
  longint unsigned m_total [2], m_rd [2], cap [2];
  logic m_sat [2];
  longint unsigned m_peak;
  logic [63:0] pend [$];

  function automatic int bin_of(longint unsigned c, longint unsigned m);
    if (m == 0) return 0;
    if (c >= m) return 15;
    return int'((c * 16) / m);
  endfunction

  task automatic model_zero();
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 16; b++) m_bin[k][b] = 0;
      m_total[k] = 0;
      m_sat[k] = 1'b0;
    end
    m_peak = 0;
    pend.delete();
  endtask

  initial begin
    cap[0] = 64'hFFFF_FFFF;
    cap[1] = 15;
    model_zero();
    m_rd[0] = 0; m_rd[1] = 0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        model_zero();
        m_rd[0] = 0; m_rd[1] = 0;
      end else begin
        for (int k = 0; k < 2; k++) m_rd[k] = m_bin[k][ri];
        if (clr) model_zero();
        else begin
          if (pend.size() > 0) begin
            logic [63:0] s;
            int b;
            s = pend.pop_front();
            b = bin_of(s[31:0], s[63:32]);
            for (int k = 0; k < 2; k++) begin
              if (m_bin[k][b] == cap[k]) m_sat[k] = 1'b1; else m_bin[k][b]++;
              if (m_total[k] == cap[k]) m_sat[k] = 1'b1; else m_total[k]++;
            end
            if (s[31:0] > m_peak) m_peak = s[31:0];
          end
          if (en) pend.push_back({mx, cu});
        end
      end
    end
  end

  task automatic check(string name, longint unsigned act, longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint unsigned exp_peak();
`ifdef SA_PERFMON_PEAK_EN
    return m_peak;
`else
    return 0;
`endif
  endfunction

  initial forever begin
    @(negedge clk);
    check("d0.rd_data", if0.rd_data, m_rd[0]);
    check("d0.total",   if0.total,   m_total[0]);
    check("d0.sat",     if0.sat,     m_sat[0]);
    check("d0.peak",    if0.peak,    exp_peak());
    check("d1.rd_data", if1.rd_data, m_rd[1]);
    check("d1.total",   if1.total,   m_total[1]);
    check("d1.sat",     if1.sat,     m_sat[1]);
    check("d1.peak",    if1.peak,    exp_peak());
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic samp(logic [31:0] c, logic [31:0] m);
    en = 1'b1; cu = c; mx = m;
    tick();
    en = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic read_bin(int idx, longint unsigned e0, longint unsigned e1, string name);
    ri = 4'(idx);
    tick();
    check({name, ".d0"}, if0.rd_data, e0);
    check({name, ".d1"}, if1.rd_data, e1);
  endtask

  initial begin
    tick(2);
    check("reset.total", if0.total, 0);
    check("reset.rd_data", if0.rd_data, 0);
    rstn = 1'b1;
    tick();
    // 1: binning at max=256
    en = 1'b1; mx = 256;
    cu = 0;   tick();
    cu = 128; tick();
    cu = 255; tick();
    cu = 256; tick();
    en = 1'b0;
    tick(3);
    for (int i = 0; i < 16; i++) begin
      longint unsigned e;
      e = (i == 0 || i == 8) ? 1 : (i == 15) ? 2 : 0;
      read_bin(i, e, e, "t1.bin");
      check("t1.model", m_bin[0][i], e);
    end
    check("t1.total", if0.total, 4);
    do_clear();
    // 2: max=0 always lands in bin 0
    for (int i = 0; i < 5; i++) samp(77, 0);
    tick(3);
    check("t2.total", if0.total, 5);
    check("t2.sat", if0.sat, 0);
    read_bin(0, 5, 5, "t2.bin0");
    read_bin(1, 0, 0, "t2.bin1");
    do_clear();
    // 3: 4-bit counters saturate at 15
    en = 1'b1; cu = 48; mx = 256;
    tick(16);
    en = 1'b0;
    tick(3);
    check("t3.total.d1", if1.total, 15);
    check("t3.sat.d1", if1.sat, 1);
    check("t3.total.d0", if0.total, 16);
    check("t3.sat.d0", if0.sat, 0);
    read_bin(3, 16, 15, "t3.bin3");
    do_clear();
    tick();
    check("t3.clr.total", if1.total, 0);
    check("t3.clr.sat", if1.sat, 0);
    read_bin(3, 0, 0, "t3.clr.bin3");
    // 4: clear kills the in-flight and same-cycle samples
    en = 1'b1; cu = 48; mx = 256;
    tick();
    clr = 1'b1;
    tick();
    en = 1'b0; clr = 1'b0;
    tick(3);
    check("t4.total", if0.total, 0);
    read_bin(3, 0, 0, "t4.bin3");
    // 5: peak
    samp(10, 1000); samp(300, 1000); samp(42, 1000);
    tick(3);
`ifdef SA_PERFMON_PEAK_EN
    check("t5.peak", if0.peak, 300);
`else
    check("t5.peak", if0.peak, 0);
`endif
    check("t5.total", if0.total, 3);
    // 6: async reset mid-stream, then first sample latency
    en = 1'b1; cu = 5; mx = 10;
    tick(3);
    #2 rstn = 1'b0;
    #1;
    check("t6.rst.total", if0.total, 0);
    check("t6.rst.rd", if0.rd_data, 0);
    check("t6.rst.sat", if1.sat, 0);
    check("t6.rst.peak", if0.peak, 0);
    tick();
    rstn = 1'b1; en = 1'b0;
    tick();
    samp(5, 10);
    check("t6.lat1", if0.total, 0);
    tick();
    check("t6.lat2", if0.total, 1);
    read_bin(8, 1, 1, "t6.bin8");
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
